// File: rtl/spi_pkg.sv
// Shared types and constants for the ISM330DHCX SPI command serializer.
// Holds the FSM state encoding, command bit positions and the read-length clamp helper.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } spi_state_e;

  localparam logic        SPI_RD_BIT = 1'b1;
  localparam int unsigned HDR_BITS   = 16;

  localparam logic [6:0] WHO_AM_I = 7'h0F;
  localparam logic [6:0] CTRL1_XL = 7'h10;
  localparam logic [6:0] OUTX_L_G = 7'h22;

  function automatic logic [2:0] clamp_rd_bytes(input logic [2:0] n, input logic [2:0] max_n);
    return (n > max_n) ? max_n : n;
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for SCK: while enabled, emits alternating rise/fall strobes
// every CLK_DIV clocks, starting from the low half.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck_rise,
  output logic sck_fall
);

  localparam int HP_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV + 1);

  logic [HP_W-1:0] hp_cnt_r;
  logic            phase_r;
  logic            half_end_s;

  assign half_end_s = en && (hp_cnt_r == HP_W'(CLK_DIV - 32'd1));
  assign sck_rise   = half_end_s && !phase_r;
  assign sck_fall   = half_end_s && phase_r;

  // half-period counter and current SCK phase (0 = low half)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt_r <= '0;
      phase_r  <= 1'b0;
    end else if (!en) begin
      hp_cnt_r <= '0;
      phase_r  <= 1'b0;
    end else if (half_end_s) begin
      hp_cnt_r <= '0;
      phase_r  <= !phase_r;
    end else begin
      hp_cnt_r <= hp_cnt_r + HP_W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_serializer.sv
// SPI mode-3 transmit serializer: frames a 16-bit command plus optional read dummy bytes
// onto rp2350_cs/sck/mosi with programmable CS setup, hold and inter-frame gap.
module spi_cmd_serializer
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned CS_SETUP     = 2,
  parameter int unsigned CS_HOLD      = 2,
  parameter int unsigned CS_GAP       = 4,
  parameter int unsigned MAX_RD_BYTES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_word,
  input  logic [2:0]  cmd_rd_bytes,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic        xfer_done,
  output logic        busy,
  output logic        rp2350_cs,
  output logic        rp2350_sck,
  output logic        rp2350_mosi
);

  localparam int BIT_W = $clog2(16 + 8 * MAX_RD_BYTES + 1);
  localparam int unsigned WAIT_MAX = (CS_SETUP > CS_HOLD) ?
      ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  spi_state_e        state_r, next_state_s;
  logic [15:0]       sreg_r;
  logic [BIT_W-1:0]  total_bits_r, bit_idx_r, total_nx_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [2:0]        rd_len_s;
  logic              accept_s, wait_done_s, last_bit_s, shift_load_s;
  logic              sck_rise_s, sck_fall_s;
  logic              cs_r, sck_r, mosi_r, busy_r, done_r, ready_r;
  logic              cs_nx_s, sck_nx_s, mosi_nx_s, busy_nx_s, done_nx_s, ready_nx_s;

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_r == SHIFT),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s)
  );

  assign accept_s     = (state_r == IDLE) && cmd_valid;
  assign rd_len_s     = clamp_rd_bytes(cmd_rd_bytes, 3'(MAX_RD_BYTES));
  assign total_nx_s   = (cmd_word[15] == SPI_RD_BIT) ?
                        BIT_W'(HDR_BITS) + BIT_W'({rd_len_s, 3'b000}) : BIT_W'(HDR_BITS);
  assign last_bit_s   = (bit_idx_r == total_bits_r - BIT_W'(1));
  assign shift_load_s = ((state_r == SETUP) && wait_done_s) ||
                        ((state_r == SHIFT) && sck_fall_s && !last_bit_s);

  // end-of-interval decode for the timed CS phases
  always_comb begin
    case (state_r)
      SETUP:   wait_done_s = (wait_cnt_r == WAIT_W'(CS_SETUP - 32'd1));
      HOLD:    wait_done_s = (wait_cnt_r == WAIT_W'(CS_HOLD - 32'd1));
      GAP:     wait_done_s = (wait_cnt_r == WAIT_W'(CS_GAP - 32'd1));
      default: wait_done_s = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= next_state_s;
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    next_state_s = accept_s ? SETUP : IDLE;
      SETUP:   next_state_s = wait_done_s ? SHIFT : SETUP;
      SHIFT:   next_state_s = (sck_fall_s && last_bit_s) ? HOLD : SHIFT;
      HOLD:    next_state_s = wait_done_s ? GAP : HOLD;
      GAP:     next_state_s = wait_done_s ? IDLE : GAP;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM outputs, computed one cycle ahead so every pin comes straight off a flop
  always_comb begin
    case (next_state_s)
      SETUP, SHIFT, HOLD: cs_nx_s = 1'b0;
      default:            cs_nx_s = 1'b1;
    endcase
    if (next_state_s != SHIFT) begin
      sck_nx_s  = 1'b1;
      mosi_nx_s = 1'b0;
    end else if ((state_r != SHIFT) || sck_fall_s) begin
      sck_nx_s  = 1'b0;
      mosi_nx_s = sreg_r[15];
    end else if (sck_rise_s) begin
      sck_nx_s  = 1'b1;
      mosi_nx_s = mosi_r;
    end else begin
      sck_nx_s  = sck_r;
      mosi_nx_s = mosi_r;
    end
    done_nx_s  = (state_r == HOLD) && (next_state_s == GAP);
    busy_nx_s  = (next_state_s != IDLE);
    ready_nx_s = (next_state_s == IDLE);
  end

  // pin and handshake output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_r    <= 1'b1;
      sck_r   <= 1'b1;
      mosi_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      cs_r    <= cs_nx_s;
      sck_r   <= sck_nx_s;
      mosi_r  <= mosi_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
      ready_r <= ready_nx_s;
    end
  end

  // command latch, shift register (zero-filled past the header) and bit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_r       <= 16'h0000;
      total_bits_r <= '0;
      bit_idx_r    <= '0;
    end else if (accept_s) begin
      sreg_r       <= cmd_word;
      total_bits_r <= total_nx_s;
      bit_idx_r    <= '0;
    end else if (shift_load_s) begin
      sreg_r    <= {sreg_r[14:0], 1'b0};
      bit_idx_r <= (state_r == SHIFT) ? bit_idx_r + BIT_W'(1) : bit_idx_r;
    end
  end

  // interval counter for SETUP/HOLD/GAP, cleared on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if ((state_r != next_state_s) ||
                 !((state_r == SETUP) || (state_r == HOLD) || (state_r == GAP))) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end
  end

  assign rp2350_cs   = cs_r;
  assign rp2350_sck  = sck_r;
  assign rp2350_mosi = mosi_r;
  assign busy        = busy_r;
  assign xfer_done   = done_r;
  assign cmd_ready   = ready_r;

endmodule
